// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module : apb_pkg
// Brief  : Shared types and constants for the APB master bridge: the FSM
//          state encoding, the default wait-state timeout, the response
//          record layout, and a helper that sizes the timeout counter.
// Rev    : 1.0
// ============================================================================
package apb_pkg;

    localparam int APB_TIMEOUT_DEFAULT = 16;
    localparam int APB_DATA_W          = 32;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2,
        APB_RESP   = 2'd3
    } apb_mst_st_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    // Counter width able to hold 0..n; a zero timeout still needs one bit.
    function automatic int apb_cnt_width(input int n);
        if (n <= 0) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module : apb_master_bridge
// Brief  : Turns a valid/ready command stream into APB3 transfers to a single
//          slave and returns the result on a valid/ready response channel.
//          One transfer in flight at a time; a non-responding slave is cut
//          off after TIMEOUT_CYCLES ACCESS cycles (0 = wait forever).
// Ports  : pclk/preset       - clock, synchronous active-high reset
//          cmd_*             - command channel (valid/ready, write, addr, wdata)
//          rsp_*             - response channel (valid/ready, rdata, err, timeout)
//          psel..pwdata      - APB requester outputs (all registered)
//          pready/pslverr/prdata - APB completer inputs
// Rev    : 1.0
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
    input  logic              pclk,
    input  logic              preset,
    // Command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // Response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB requester
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    localparam logic [1:0] c_st_idle   = APB_IDLE;
    localparam logic [1:0] c_st_setup  = APB_SETUP;
    localparam logic [1:0] c_st_access = APB_ACCESS;
    localparam logic [1:0] c_st_resp   = APB_RESP;

    localparam int              c_cnt_w    = apb_cnt_width(int'(TIMEOUT_CYCLES));
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = {c_cnt_w{1'b1}};
    localparam bit              c_to_en    = (TIMEOUT_CYCLES != 0);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               w_expired;

    // The counter holds the number of ACCESS cycles already spent without
    // pready, so the Nth ACCESS cycle sees N-1 here.
    assign w_expired = c_to_en && (r_wait_cnt == c_cnt_last);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= c_st_idle;
            r_wait_cnt  <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid && cmd_ready) begin
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        cmd_ready <= 1'b0;
                        r_state   <= c_st_setup;
                    end else begin
                        // Covers the first IDLE cycle after reset, where
                        // cmd_ready is still low.
                        cmd_ready <= 1'b1;
                    end
                end

                c_st_setup: begin
                    penable    <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= c_st_access;
                end

                c_st_access: begin
                    if (pready) begin
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        r_state     <= c_st_resp;
                    end else if (w_expired) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        r_state     <= c_st_resp;
                    end else if (r_wait_cnt != c_cnt_max) begin
                        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
                    end
                end

                c_st_resp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= c_st_idle;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule : apb_master_bridge
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_apb_master_bridge
// Brief  : Self-checking bench for apb_master_bridge. The bench plays both
//          the command source and the APB slave; expected results come from
//          a transaction-level model (slave latency vs. timeout limit).
// Rev    : 1.0
// ============================================================================
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .prdata     (prdata)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transfer. The slave answers on ACCESS cycle 'lat'
    // (1 = first ACCESS cycle); lat = 0 means it never answers.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int lat, input logic err, input logic [31:0] rd,
                           input int rsp_wait);
        bit          exp_to;
        int          eff;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          psel_n, pen_n, acc, guard;

        // Reference model: outcome depends only on latency vs. limit.
        exp_to    = (lat == 0) || (lat > TO);
        eff       = exp_to ? TO : lat;
        exp_rdata = (wr || exp_to) ? 32'h0 : rd;
        exp_err   = exp_to ? 1'b0 : err;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        check("idle_latency", 64'(guard), 64'(0));
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        check("cmd_ready_drop", 64'(cmd_ready), 64'(0));

        psel_n = 0;
        pen_n  = 0;
        acc    = 0;
        guard  = 0;
        while (psel === 1'b1 && guard < 100) begin
            psel_n++;
            check("paddr", 64'(paddr), 64'(addr));
            check("pwrite", 64'(pwrite), 64'(wr));
            if (wr) check("pwdata", 64'(pwdata), 64'(wdata));
            if (penable === 1'b1) begin
                pen_n++;
                acc++;
                pready = (lat != 0) && (acc == lat);
            end else begin
                // SETUP cycle: a stray pready here must be ignored.
                pready = 1'($urandom);
            end
            pslverr = pready ? err : 1'($urandom);
            prdata  = pready ? rd : $urandom;
            tick();
            guard++;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        check("psel_cycles", 64'(psel_n), 64'(eff + 1));
        check("penable_cycles", 64'(pen_n), 64'(eff));
        check("penable_low", 64'(penable), 64'(0));

        for (int i = 0; i < rsp_wait; i++) begin
            cmd_valid = 1'b1;
            check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
            check("hold_rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
            check("hold_rsp_err", 64'(rsp_err), 64'(exp_err));
            check("hold_rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
            check("hold_cmd_ready", 64'(cmd_ready), 64'(0));
            check("hold_psel", 64'(psel), 64'(0));
            tick();
        end
        cmd_valid = 1'b0;
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        check("rsp_err", 64'(rsp_err), 64'(exp_err));
        check("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(rsp_valid), 64'(0));
        check("cmd_ready_back", 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_psel", 64'(psel), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_paddr", 64'(paddr), 64'(0));
        preset = 1'b0;
        tick();
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

        // Directed cases
        run_txn(1'b1, 32'h0,  32'hDEADBEEF, 2, 1'b0, $urandom,    0);
        run_txn(1'b0, 32'h0,  32'h0,        1, 1'b0, 32'h5555_5555, 0);
        run_txn(1'b0, 32'h10, 32'h0,        1, 1'b1, $urandom,    0);
        run_txn(1'b0, 32'h44, 32'h0,        0, 1'b1, $urandom,    0);  // never ready
        run_txn(1'b1, 32'h8,  32'h1234_5678, 1, 1'b0, $urandom,   0);
        run_txn(1'b0, 32'h20, 32'h0,        3, 1'b0, 32'hA5A5_0F0F, 5);
        run_txn(1'b0, 32'h24, 32'h0,        TO,     1'b0, 32'h0BAD_F00D, 1); // last legal cycle
        run_txn(1'b1, 32'h28, 32'h7777_0000, TO + 1, 1'b0, $urandom,  0);   // one too late

        // Reset during the second ACCESS cycle
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h30;
        cmd_wdata = 32'hCAFE_0001;
        tick();
        cmd_valid = 1'b0;
        check("abort_setup_psel", 64'(psel), 64'(1));
        tick();
        tick();
        check("abort_access_penable", 64'(penable), 64'(1));
        preset = 1'b1;
        tick();
        preset = 1'b0;
        check("abort_psel", 64'(psel), 64'(0));
        check("abort_penable", 64'(penable), 64'(0));
        check("abort_pwrite", 64'(pwrite), 64'(0));
        check("abort_paddr", 64'(paddr), 64'(0));
        check("abort_pwdata", 64'(pwdata), 64'(0));
        check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        check("abort_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("abort_rsp_err", 64'(rsp_err), 64'(0));
        check("abort_rsp_timeout", 64'(rsp_timeout), 64'(0));
        check("abort_cmd_ready", 64'(cmd_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_rsp", 64'(rsp_valid), 64'(0));
            check("abort_no_psel", 64'(psel), 64'(0));
        end
        check("abort_ready_again", 64'(cmd_ready), 64'(1));

        // Randomized transfers
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, TO + 2)), 1'($urandom), $urandom,
                    int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_apb_master_bridge
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Converts a simple valid/ready command stream into APB3 transfers toward one APB slave, and returns each read data / error result on a valid/ready response channel. It sits directly upstream of the peripheral register slaves: the system-side controller issues commands, and this block owns psel/penable/paddr/pwrite/pwdata. It handles one outstanding transfer at a time and adds a bounded wait-state timeout so that a non-responding slave cannot hang the bus.

Parameters:
ADDR_W, 32, width of cmd_addr and paddr
DATA_W, 32, width of write/read data
TIMEOUT_CYCLES, 16, maximum ACCESS cycles without pready before the transfer is aborted; 0 disables the timeout

Ports:
pclk  in  1  clock; all logic on the rising edge
preset  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block accepts a command this cycle
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_err  out  1  pslverr was sampled high with pready
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pready  in  1  slave ready
pslverr  in  1  slave error, valid only while pready=1
prdata  in  DATA_W  slave read data, valid only while pready=1

Behaviour:
- Reset (preset=1 at a clock edge) sets all outputs to 0 (psel, penable, pwrite, paddr, pwdata, rsp_*, cmd_ready) and the FSM to IDLE. Reset mid-transfer aborts the transfer immediately, with no response.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs and rsp_* are registered.
- IDLE: cmd_ready=1 (registered, so it is high in the first cycle after entering IDLE). If cmd_valid && cmd_ready, the block latches cmd_write/addr/wdata into pwrite/paddr/pwdata, sets psel=1 and penable=0, drops cmd_ready, and moves to SETUP.
- SETUP: lasts exactly 1 cycle, then penable=1 and the state moves to ACCESS. The timeout counter is cleared.
- ACCESS: psel=penable=1, and paddr/pwrite/pwdata stay stable.
  - If pready=1: capture rsp_rdata = pwrite ? 0 : prdata and rsp_err = pslverr, with rsp_timeout=0.
  - Timeout case: if pready=0 and the counter reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0), set rsp_timeout=1, rsp_err=0 and rsp_rdata=0.
  - In either case the block then sets psel=penable=0 and rsp_valid=1, and goes to RESP.
  - Otherwise the counter increments and saturates, and the block stays in ACCESS.
  - pslverr and prdata are ignored while pready=0.
- RESP: rsp_valid held with rsp_* stable until rsp_ready=1. On that handshake: rsp_valid=0, and the next cycle is IDLE with cmd_ready=1.
- Back-to-back: the minimum command-to-command period is 4 cycles (IDLE, SETUP, ACCESS with pready in the first cycle, RESP with rsp_ready=1).
- paddr/pwdata/pwrite retain their last values after a transfer; they are not cleared.
- A slave that asserts pready one cycle after penable rises (registered pready) costs one extra ACCESS cycle. That is not a timeout.
- A command presented during SETUP, ACCESS or RESP is not accepted (cmd_ready=0) and must be held by the source.
- A pready pulse outside ACCESS is ignored.

Decomposition:
- Package apb_pkg: state enum apb_mst_st_t (IDLE, SETUP, ACCESS, RESP), localparam APB_TIMEOUT_DEFAULT=16, and a packed struct apb_rsp_t {rdata, err, timeout}.
- Single module. The timeout counter is inline; width $clog2(TIMEOUT_CYCLES+1), min 1. No sub-module is warranted.

Test Plan:
- Write 0x0 ← 0xDEADBEEF, with the slave giving pready on the 2nd ACCESS cycle → psel high 3 cycles, penable high 2 cycles; rsp_valid with rsp_err=0, rsp_timeout=0, rsp_rdata=0.
- Read 0x0, with the slave returning prdata=0x5555_5555 and pready on the 1st ACCESS cycle → rsp_rdata=0x5555_5555, rsp_err=0.
- Read 0x10, with the slave giving pready=1 and pslverr=1 → rsp_err=1, rsp_rdata=0x0000_0000 only if prdata=0 (check that captured prdata equals the bus value), rsp_timeout=0.
- Slave never asserts pready, TIMEOUT_CYCLES=16 → after exactly 16 ACCESS cycles psel=0, rsp_timeout=1 and rsp_err=0; a following command is accepted normally.
- rsp_ready held low for 5 cycles with a second cmd_valid pending → cmd_ready stays 0, no APB activity, rsp_* stable; the second command starts the cycle after the response handshake plus IDLE.
- preset asserted in the 2nd ACCESS cycle → next cycle all outputs are 0 and the state is IDLE; no rsp_valid is issued for the aborted transfer.
